memaccess_stage: RTL

- Parametrised successor of the single-cycle memory access stage (one control bit, 16-bit address and data, combinational memory return).
- Accepts load/store requests from the execute stage through a valid/ready handshake and drives a variable-latency data-memory port using req/ack.
- Supports direct and indirect (pointer-fetch, LDI/STI-style) modes, a configurable ack timeout, and a registered response with a completion pulse back to the pipeline.

---
 rtl/memaccess_stage_if.sv | 53 +++++
 rtl/memaccess_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/memaccess_stage_if.sv
// memaccess_stage_if
//   Bundles the three channels of the memory access stage:
//     request  : req_valid/req_ready handshake carrying mode, address and store data
//     memory   : req/ack data-memory port with address, write enable and data
//     response : rsp_valid/rsp_ready handshake carrying load data, error flag and
//                the completion pulse back to the pipeline
//   Modports:
//     master : the stage itself (accepts requests, drives memory, returns responses)
//     slave  : the surroundings (execute stage, data memory, response consumer)
interface memaccess_stage_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // request channel
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_mode;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // data-memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              completedata;

  modport master (
    input  req_valid, req_mode, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output rsp_valid, rsp_data, rsp_err, completedata,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_mode, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  rsp_valid, rsp_data, rsp_err, completedata,
    output rsp_ready
  );
endinterface

// File: rtl/memaccess_stage.sv
// memaccess_stage
//   Memory access stage: takes one load/store request at a time from the
//   execute stage, performs it on a variable-latency req/ack data memory
//   (optionally fetching a pointer first for indirect modes), and returns a
//   registered response. Accesses that see no ack within TIMEOUT_CYC cycles
//   complete with rsp_err=1 (TIMEOUT_CYC=0 waits forever).
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : memaccess_stage_if.master (request, memory and response channels)
//   Mode encoding: 00 direct read, 01 direct write, 10 indirect read,
//   11 indirect write. ADDR_W must not exceed DATA_W, since a pointer is
//   taken from the low ADDR_W bits of the read data.
module memaccess_stage #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clock,
  input  logic              reset,
  memaccess_stage_if.master bus
);

  // Wide enough to hold TIMEOUT_CYC itself.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    ACC  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;        // mode[0] of the accepted request
  logic [ADDR_W-1:0] addr_q, addr_d;    // pointer location, then effective address
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;    // response data
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // cycles of the current mem_req without ack
  logic [CNT_W-1:0]  cnt_inc;
  logic              timed_out;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  // The cycle that would bring the counter to TIMEOUT_CYC ends the access.
  assign timed_out = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // req_ready is 1 throughout IDLE, so req_valid alone is the handshake.
        if (bus.req_valid) begin
          we_d    = bus.req_mode[0];
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          state_d = bus.req_mode[1] ? PTR : ACC;
        end
      end

      PTR: begin
        if (bus.mem_ack) begin
          // Pointer becomes the access address; mem_req stays high into ACC
          // and the timeout window restarts.
          addr_d  = bus.mem_rdata[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = ACC;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ACC: begin
        // The ack is checked first so it wins over a same-cycle timeout.
        if (bus.mem_ack) begin
          data_d  = we_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this clock edge, independent of order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registers, so mem_req follows acceptance by
  // one cycle, and a reset drops everything at once, which also makes any
  // late ack irrelevant.
  logic in_mem;
  logic writing;
  logic in_resp;

  assign in_mem  = (state_q == PTR) || (state_q == ACC);
  assign writing = (state_q == ACC) && we_q;
  assign in_resp = (state_q == RESP);

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.mem_req      = in_mem;
  assign bus.mem_we       = writing;
  assign bus.mem_addr     = in_mem  ? addr_q  : '0;
  assign bus.mem_wdata    = writing ? wdata_q : '0;
  assign bus.rsp_valid    = in_resp;
  assign bus.rsp_data     = in_resp ? data_q  : '0;
  assign bus.rsp_err      = in_resp && err_q;
  assign bus.completedata = in_resp && bus.rsp_ready && !err_q;

endmodule
